// File: rtl/dbg_ctrl.sv
// Debug controller: bridges a host command stream onto the lsu memory port and
// the core debug channel, with burst transfers, wait timeouts and reset pulses.
module dbg_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_AW     = 5,
  parameter int LEN_W      = 4,
  parameter int TIMEOUT    = 1024,
  parameter int RST_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [7:0]          cmd_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [LEN_W-1:0]    len_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic                wvalid_i,
  output logic                wready_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                rvalid_o,
  input  logic                rready_i,
  output logic                done_o,
  output logic [1:0]          status_o,
  output logic                core_rst_req_o,
  output logic                periph_rst_req_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic [DATA_W/8-1:0] mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_valid_i,
  output logic [7:0]          dbg_cmd_o,
  output logic [REG_AW-1:0]   dbg_addr_o,
  output logic [DATA_W-1:0]   dbg_wdata_o,
  input  logic [DATA_W-1:0]   dbg_rdata_i,
  input  logic                dbg_done_i
);

  localparam int BYTES   = DATA_W / 8;
  localparam int CNT_MAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);

  localparam logic [7:0] CMD_NOP    = 8'h00;
  localparam logic [7:0] CMD_RD     = 8'h01;
  localparam logic [7:0] CMD_WR     = 8'h02;
  localparam logic [7:0] CMD_HALT   = 8'h03;
  localparam logic [7:0] CMD_RESUME = 8'h04;
  localparam logic [7:0] CMD_RST_C  = 8'h05;
  localparam logic [7:0] CMD_RST_P  = 8'h06;
  localparam logic [7:0] CMD_RST_B  = 8'h07;
  localparam logic [7:0] CMD_RRD    = 8'h10;
  localparam logic [7:0] CMD_RWR    = 8'h20;
  localparam logic [7:0] CMD_STAT   = 8'h30;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_TO  = 2'b01;
  localparam logic [1:0] ST_ILL = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WDATA = 3'd1,
    S_MEM   = 3'd2,
    S_RDATA = 3'd3,
    S_DBG   = 3'd4,
    S_RST   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t             state_r, state_next_s;
  logic [7:0]         cmd_r, cmd_next_s;
  logic [ADDR_W-1:0]  addr_r, addr_next_s;
  logic [LEN_W-1:0]   len_r, len_next_s;
  logic [CNT_W-1:0]   cnt_r, cnt_next_s;
  logic [DATA_W-1:0]  wbuf_r, wbuf_next_s;
  logic               sticky_to_r, sticky_to_next_s;
  logic               sticky_ill_r, sticky_ill_next_s;
  logic [1:0]         status_next_s;
  logic               last_s, to_hit_s;

  logic               cmd_ready_next_s, wready_next_s, rvalid_next_s, done_next_s;
  logic [1:0]         status_o_next_s;
  logic               core_rst_next_s, periph_rst_next_s;
  logic               mem_read_next_s, mem_write_next_s;
  logic [BYTES-1:0]   mem_we_next_s;
  logic [DATA_W-1:0]  rdata_next_s, dbg_wdata_next_s;
  logic [7:0]         dbg_cmd_next_s;
  logic [REG_AW-1:0]  dbg_addr_next_s;

  assign last_s   = (len_r == {LEN_W{1'b0}});
  assign to_hit_s = (TIMEOUT != 0) && (cnt_r == TO_LAST);

  // State, datapath and output registers; reset drops every request at once.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_r          <= S_IDLE;
      cmd_r            <= 8'h00;
      addr_r           <= {ADDR_W{1'b0}};
      len_r            <= {LEN_W{1'b0}};
      cnt_r            <= {CNT_W{1'b0}};
      wbuf_r           <= {DATA_W{1'b0}};
      sticky_to_r      <= 1'b0;
      sticky_ill_r     <= 1'b0;
      cmd_ready_o      <= 1'b1;
      wready_o         <= 1'b0;
      rvalid_o         <= 1'b0;
      rdata_o          <= {DATA_W{1'b0}};
      done_o           <= 1'b0;
      status_o         <= 2'b00;
      core_rst_req_o   <= 1'b0;
      periph_rst_req_o <= 1'b0;
      mem_read_o       <= 1'b0;
      mem_write_o      <= 1'b0;
      mem_we_o         <= {BYTES{1'b0}};
      mem_addr_o       <= {ADDR_W{1'b0}};
      mem_wdata_o      <= {DATA_W{1'b0}};
      dbg_cmd_o        <= 8'h00;
      dbg_addr_o       <= {REG_AW{1'b0}};
      dbg_wdata_o      <= {DATA_W{1'b0}};
    end else begin
      state_r          <= state_next_s;
      cmd_r            <= cmd_next_s;
      addr_r           <= addr_next_s;
      len_r            <= len_next_s;
      cnt_r            <= cnt_next_s;
      wbuf_r           <= wbuf_next_s;
      sticky_to_r      <= sticky_to_next_s;
      sticky_ill_r     <= sticky_ill_next_s;
      cmd_ready_o      <= cmd_ready_next_s;
      wready_o         <= wready_next_s;
      rvalid_o         <= rvalid_next_s;
      rdata_o          <= rdata_next_s;
      done_o           <= done_next_s;
      status_o         <= status_o_next_s;
      core_rst_req_o   <= core_rst_next_s;
      periph_rst_req_o <= periph_rst_next_s;
      mem_read_o       <= mem_read_next_s;
      mem_write_o      <= mem_write_next_s;
      mem_we_o         <= mem_we_next_s;
      mem_addr_o       <= addr_next_s;
      mem_wdata_o      <= wbuf_next_s;
      dbg_cmd_o        <= dbg_cmd_next_s;
      dbg_addr_o       <= dbg_addr_next_s;
      dbg_wdata_o      <= dbg_wdata_next_s;
    end
  end

  // Next state plus next datapath values; a response arriving with the timeout wins.
  always_comb begin
    state_next_s      = state_r;
    cmd_next_s        = cmd_r;
    addr_next_s       = addr_r;
    len_next_s        = len_r;
    wbuf_next_s       = wbuf_r;
    sticky_to_next_s  = sticky_to_r;
    sticky_ill_next_s = sticky_ill_r;
    status_next_s     = ST_OK;
    case (state_r)
      S_IDLE: begin
        if (cmd_valid_i) begin
          cmd_next_s  = cmd_i;
          addr_next_s = addr_i;
          len_next_s  = len_i;
          case (cmd_i)
            CMD_NOP:                        state_next_s = S_DONE;
            CMD_RD:                         state_next_s = S_MEM;
            CMD_WR, CMD_RWR:                state_next_s = S_WDATA;
            CMD_HALT, CMD_RESUME, CMD_RRD:  state_next_s = S_DBG;
            CMD_RST_C, CMD_RST_P, CMD_RST_B: state_next_s = S_RST;
            CMD_STAT:                       state_next_s = S_RDATA;
            default: begin
              state_next_s      = S_DONE;
              status_next_s     = ST_ILL;
              sticky_ill_next_s = 1'b1;
            end
          endcase
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_WDATA: begin
        if (wvalid_i) begin
          wbuf_next_s  = wdata_i;
          state_next_s = (cmd_r == CMD_RWR) ? S_DBG : S_MEM;
        end else begin
          state_next_s = S_WDATA;
        end
      end
      S_MEM: begin
        if (mem_valid_i) begin
          if (cmd_r == CMD_RD) begin
            state_next_s = S_RDATA;
          end else if (last_s) begin
            state_next_s = S_DONE;
          end else begin
            state_next_s = S_WDATA;
            addr_next_s  = addr_r + ADDR_W'(BYTES);
            len_next_s   = len_r - LEN_W'(1);
          end
        end else if (to_hit_s) begin
          state_next_s     = S_DONE;
          status_next_s    = ST_TO;
          sticky_to_next_s = 1'b1;
        end else begin
          state_next_s = S_MEM;
        end
      end
      S_RDATA: begin
        if (rready_i) begin
          if (cmd_r == CMD_STAT) begin
            state_next_s      = S_DONE;
            sticky_to_next_s  = 1'b0;
            sticky_ill_next_s = 1'b0;
          end else if ((cmd_r == CMD_RD) && !last_s) begin
            state_next_s = S_MEM;
            addr_next_s  = addr_r + ADDR_W'(BYTES);
            len_next_s   = len_r - LEN_W'(1);
          end else begin
            state_next_s = S_DONE;
          end
        end else begin
          state_next_s = S_RDATA;
        end
      end
      S_DBG: begin
        if (dbg_done_i) begin
          state_next_s = (cmd_r == CMD_RRD) ? S_RDATA : S_DONE;
        end else if (to_hit_s) begin
          state_next_s     = S_DONE;
          status_next_s    = ST_TO;
          sticky_to_next_s = 1'b1;
        end else begin
          state_next_s = S_DBG;
        end
      end
      S_RST: begin
        if (cnt_r == RST_LAST) begin
          state_next_s = S_DONE;
        end else begin
          state_next_s = S_RST;
        end
      end
      S_DONE:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
    if (state_next_s != state_r) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end
  end

  // Output decode from the upcoming state so every output leaves a register.
  always_comb begin
    cmd_ready_next_s  = (state_next_s == S_IDLE);
    wready_next_s     = (state_next_s == S_WDATA);
    rvalid_next_s     = (state_next_s == S_RDATA);
    done_next_s       = (state_next_s == S_DONE);
    status_o_next_s   = (state_next_s == S_DONE) ? status_next_s : 2'b00;
    core_rst_next_s   = (state_next_s == S_RST) && ((cmd_next_s == CMD_RST_C) || (cmd_next_s == CMD_RST_B));
    periph_rst_next_s = (state_next_s == S_RST) && ((cmd_next_s == CMD_RST_P) || (cmd_next_s == CMD_RST_B));
    mem_read_next_s   = (state_next_s == S_MEM) && (cmd_next_s == CMD_RD);
    mem_write_next_s  = (state_next_s == S_MEM) && (cmd_next_s == CMD_WR);
    mem_we_next_s     = mem_write_next_s ? {BYTES{1'b1}} : {BYTES{1'b0}};
    dbg_cmd_next_s    = 8'h00;
    dbg_addr_next_s   = {REG_AW{1'b0}};
    dbg_wdata_next_s  = {DATA_W{1'b0}};
    rdata_next_s      = rdata_o;
    if (state_next_s == S_DBG) begin
      dbg_addr_next_s = addr_next_s[REG_AW-1:0];
      case (cmd_next_s)
        CMD_HALT:   dbg_cmd_next_s = 8'h01;
        CMD_RESUME: dbg_cmd_next_s = 8'h02;
        CMD_RRD:    dbg_cmd_next_s = 8'h03;
        CMD_RWR: begin
          dbg_cmd_next_s   = 8'h04;
          dbg_wdata_next_s = wbuf_next_s;
        end
        default:    dbg_cmd_next_s = 8'h00;
      endcase
    end else begin
      dbg_cmd_next_s = 8'h00;
    end
    // Read data is latched only on entry to RDATA so it stays stable during host stalls.
    if ((state_next_s == S_RDATA) && (state_r != S_RDATA)) begin
      case (state_r)
        S_MEM:   rdata_next_s = mem_rdata_i;
        S_DBG:   rdata_next_s = dbg_rdata_i;
        default: rdata_next_s = {{(DATA_W-2){1'b0}}, sticky_ill_r, sticky_to_r};
      endcase
    end else begin
      rdata_next_s = rdata_o;
    end
  end

endmodule

// File: tb/tb_dbg_ctrl.sv
// Directed bench for dbg_ctrl with behavioural memory and core-debug responders.
module tb_dbg_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i, cmd_ready_o;
  logic [7:0]  cmd_i;
  logic [31:0] addr_i;
  logic [3:0]  len_i;
  logic [31:0] wdata_i;
  logic        wvalid_i, wready_o;
  logic [31:0] rdata_o;
  logic        rvalid_o, rready_i;
  logic        done_o;
  logic [1:0]  status_o;
  logic        core_rst_req_o, periph_rst_req_o;
  logic        mem_read_o, mem_write_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        mem_valid_i = 1'b0;
  logic [7:0]  dbg_cmd_o;
  logic [4:0]  dbg_addr_o;
  logic [31:0] dbg_wdata_o;
  logic [31:0] dbg_rdata_i = 32'h0;
  logic        dbg_done_i = 1'b0;

  int          n_chk = 0;
  int          n_pass = 0;
  int          done_cnt = 0;
  logic        dbg_en = 1'b1;
  logic [31:0] regs [32];
  logic [31:0] maddr_q[$];
  logic [31:0] mwe_q[$];
  logic [31:0] mwd_q[$];
  logic [31:0] rq[$];

  always #5 clk = ~clk;

  dbg_ctrl #(
    .DATA_W(32), .ADDR_W(32), .REG_AW(5), .LEN_W(4), .TIMEOUT(8), .RST_CYCLES(4)
  ) dut (
    .clk(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_i(cmd_i), .addr_i(addr_i), .len_i(len_i),
    .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .done_o(done_o), .status_o(status_o),
    .core_rst_req_o(core_rst_req_o), .periph_rst_req_o(periph_rst_req_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_valid_i(mem_valid_i),
    .dbg_cmd_o(dbg_cmd_o), .dbg_addr_o(dbg_addr_o), .dbg_wdata_o(dbg_wdata_o),
    .dbg_rdata_i(dbg_rdata_i), .dbg_done_i(dbg_done_i)
  );

  // Memory: answers one cycle after seeing a request; read data = 0xA0 + word index from 0x100.
  always @(negedge clk) begin
    if ((mem_read_o || mem_write_o) && !mem_valid_i) begin
      mem_valid_i = 1'b1;
      mem_rdata_i = 32'hA0 + ((mem_addr_o - 32'h100) >> 2);
      maddr_q.push_back(mem_addr_o);
      mwe_q.push_back({28'h0, mem_we_o});
      mwd_q.push_back(mem_wdata_o);
    end else begin
      mem_valid_i = 1'b0;
    end
  end

  // Core debug model: register file echo; silent when dbg_en is low.
  always @(negedge clk) begin
    if (dbg_en && (dbg_cmd_o != 8'h00) && !dbg_done_i) begin
      dbg_done_i = 1'b1;
      if (dbg_cmd_o == 8'h04) regs[dbg_addr_o] = dbg_wdata_o;
      dbg_rdata_i = regs[dbg_addr_o];
    end else begin
      dbg_done_i = 1'b0;
    end
  end

  // Handshake monitors use pre-edge values, i.e. exactly what the DUT samples.
  always @(posedge clk) begin
    if (rvalid_o && rready_i) rq.push_back(rdata_o);
    if (done_o) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
  endtask

  task automatic send(input logic [7:0] c, input logic [31:0] a, input logic [3:0] l);
    int n = 0;
    while (!cmd_ready_o && n < 20) begin @(negedge clk); n++; end
    check("cmd_ready", {31'h0, cmd_ready_o}, 32'h1);
    cmd_valid_i = 1'b1; cmd_i = c; addr_i = a; len_i = l;
    @(negedge clk);
    cmd_valid_i = 1'b0; cmd_i = 8'hEE; addr_i = 32'h0; len_i = 4'h0;
  endtask

  task automatic wait_done(input string tag, output logic [1:0] st);
    int n = 0;
    while (!done_o && n < 200) begin @(negedge clk); n++; end
    check({tag, "_done"}, {31'h0, done_o}, 32'h1);
    st = status_o;
    @(negedge clk);
  endtask

  task automatic write_beat(input logic [31:0] d, input int gap);
    int n = 0;
    int bad = 0;
    while (!wready_o && n < 50) begin @(negedge clk); n++; end
    check("wready", {31'h0, wready_o}, 32'h1);
    repeat (gap) begin
      if (mem_write_o || mem_read_o || !wready_o) bad++;
      @(negedge clk);
    end
    check("no_req_while_waiting", bad, 0);
    wvalid_i = 1'b1; wdata_i = d;
    @(negedge clk);
    wvalid_i = 1'b0; wdata_i = 32'h0;
  endtask

  initial begin
    logic [1:0]  st;
    logic [31:0] cap_a, cap_d, first_rd;
    int          cnt_a, cnt_b, cnt_c, n, bad, d0;

    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_i = 8'h0; addr_i = 32'h0; len_i = 4'h0;
    wdata_i = 32'h0; wvalid_i = 1'b0; rready_i = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", {24'h0, cmd_ready_o, done_o, rvalid_o, wready_o, mem_read_o, mem_write_o,
          core_rst_req_o, periph_rst_req_o}, 32'h80);
    check("reset_dbg_status", {22'h0, dbg_cmd_o, status_o}, 32'h0);
    rst_i = 1'b0;
    @(negedge clk);

    // Nop: done in the cycle after acceptance, ready again the cycle after.
    send(8'h00, 32'h0, 4'h0);
    check("nop_done", {31'h0, done_o}, 32'h1);
    check("nop_ready_low", {31'h0, cmd_ready_o}, 32'h0);
    @(negedge clk);
    check("nop_ready_back", {31'h0, cmd_ready_o}, 32'h1);

    // Burst read 4 beats from 0x100.
    maddr_q.delete(); rq.delete(); d0 = done_cnt;
    send(8'h01, 32'h100, 4'h3);
    wait_done("rd", st);
    check("rd_status", {30'h0, st}, 32'h0);
    check("rd_beats", maddr_q.size(), 4);
    check("rd_words", rq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("rd_addr", (maddr_q.size() > i) ? maddr_q[i] : 32'hBAD0BAD0, 32'h100 + 32'(4 * i));
      check("rd_data", (rq.size() > i) ? rq[i] : 32'hBAD0BAD0, 32'hA0 + 32'(i));
    end
    @(negedge clk);
    check("rd_one_done", done_cnt - d0, 1);

    // Burst write across the top of the address space with gapped data.
    maddr_q.delete(); mwe_q.delete(); mwd_q.delete();
    send(8'h02, 32'hFFFF_FFFC, 4'h1);
    write_beat(32'h1111_0000, 3);
    write_beat(32'h1111_0001, 3);
    wait_done("wr", st);
    check("wr_status", {30'h0, st}, 32'h0);
    check("wr_beats", maddr_q.size(), 2);
    check("wr_addr0", (maddr_q.size() > 0) ? maddr_q[0] : 32'hBAD0BAD0, 32'hFFFF_FFFC);
    check("wr_addr1", (maddr_q.size() > 1) ? maddr_q[1] : 32'hBAD0BAD0, 32'h0000_0000);
    check("wr_we", (mwe_q.size() > 1) ? (mwe_q[0] & mwe_q[1]) : 32'h0, 32'hF);
    check("wr_data1", (mwd_q.size() > 1) ? mwd_q[1] : 32'hBAD0BAD0, 32'h1111_0001);

    // Halt with no response: times out after 8 request cycles.
    dbg_en = 1'b0;
    send(8'h03, 32'h0, 4'h0);
    cnt_a = 0; n = 0;
    while (!done_o && n < 50) begin
      if (dbg_cmd_o == 8'h01) cnt_a++;
      @(negedge clk); n++;
    end
    check("halt_req_cycles", cnt_a, 8);
    check("to_done", {31'h0, done_o}, 32'h1);
    check("to_status", {30'h0, status_o}, 32'h1);
    @(negedge clk);
    dbg_en = 1'b1;
    rq.delete();
    send(8'h30, 32'h0, 4'h0);
    wait_done("stat1", st);
    check("stat1_val", (rq.size() > 0) ? rq[0] : 32'hBAD0BAD0, 32'h1);
    rq.delete();
    send(8'h30, 32'h0, 4'h0);
    wait_done("stat2", st);
    check("stat2_val", (rq.size() > 0) ? rq[0] : 32'hBAD0BAD0, 32'h0);

    // Reset requests: both, then core only.
    for (int k = 0; k < 2; k++) begin
      send((k == 0) ? 8'h07 : 8'h05, 32'h0, 4'h0);
      cnt_a = 0; cnt_b = 0; cnt_c = 0; n = 0;
      while (!done_o && n < 50) begin
        if (core_rst_req_o && periph_rst_req_o) cnt_a++;
        else if (core_rst_req_o) cnt_b++;
        else if (periph_rst_req_o) cnt_c++;
        @(negedge clk); n++;
      end
      check("rst_both_cycles", cnt_a, (k == 0) ? 4 : 0);
      check("rst_core_cycles", cnt_b, (k == 0) ? 0 : 4);
      check("rst_periph_cycles", cnt_c, 0);
      check("rst_done", {31'h0, done_o}, 32'h1);
      @(negedge clk);
    end

    // Illegal code, then sticky illegal visible via status read.
    send(8'h55, 32'h0, 4'h0);
    wait_done("ill", st);
    check("ill_status", {30'h0, st}, 32'h2);
    rq.delete();
    send(8'h30, 32'h0, 4'h0);
    wait_done("stat3", st);
    check("stat3_val", (rq.size() > 0) ? rq[0] : 32'hBAD0BAD0, 32'h2);

    // Register write x5, then read back with a long host stall.
    send(8'h20, 32'h5, 4'hF);
    write_beat(32'hDEAD_BEEF, 0);
    cap_a = 32'hFFFF_FFFF; cap_d = 32'h0; n = 0;
    while (!done_o && n < 50) begin
      if (dbg_cmd_o == 8'h04) begin cap_a = {27'h0, dbg_addr_o}; cap_d = dbg_wdata_o; end
      @(negedge clk); n++;
    end
    check("rwr_done", {31'h0, done_o}, 32'h1);
    check("rwr_addr", cap_a, 32'h5);
    check("rwr_data", cap_d, 32'hDEAD_BEEF);
    @(negedge clk);
    check("rwr_single_beat", {31'h0, wready_o}, 32'h0);
    rready_i = 1'b0; rq.delete();
    send(8'h10, 32'h25, 4'h0);
    cap_a = 32'hFFFF_FFFF; n = 0;
    while (!rvalid_o && n < 50) begin
      if (dbg_cmd_o == 8'h03) cap_a = {27'h0, dbg_addr_o};
      @(negedge clk); n++;
    end
    check("rrd_addr", cap_a, 32'h5);
    first_rd = rdata_o; bad = 0;
    repeat (10) begin
      if (!rvalid_o || done_o || (rdata_o !== first_rd)) bad++;
      @(negedge clk);
    end
    check("rrd_stall_hold", bad, 0);
    check("rrd_data", rdata_o, 32'hDEAD_BEEF);
    rready_i = 1'b1;
    wait_done("rrd", st);
    check("rrd_status", {30'h0, st}, 32'h0);

    // Reset pulsed while the second beat of an 8-beat read is requesting.
    rq.delete();
    send(8'h01, 32'h200, 4'h7);
    n = 0;
    while (!(mem_read_o && rq.size() == 1) && n < 50) begin @(negedge clk); n++; end
    check("mid_reached", {31'h0, mem_read_o}, 32'h1);
    d0 = done_cnt;
    rst_i = 1'b1;
    #1;
    check("mid_reqs_low", {29'h0, mem_read_o, rvalid_o, done_o}, 32'h0);
    @(negedge clk);
    rst_i = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_ready", {31'h0, cmd_ready_o}, 32'h1);
    check("mid_no_done", done_cnt - d0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
